// File: rtl/alu_issue_ctrl_if.sv
// Requester, flush and CDB signals of the ALU issue controller.
// The slave modport is the controller's view; master is the driver's view.
interface alu_issue_ctrl_if #(
    parameter int NUM_REQ       = 4,
    parameter int ALU_FUNC_W    = 4,
    parameter int ADDR_W        = 32,
    parameter int PHYS_REG_BITS = 6
);
    logic [NUM_REQ-1:0]                    req_valid;
    logic [NUM_REQ-1:0][ALU_FUNC_W-1:0]    req_func;
    logic [NUM_REQ-1:0][31:0]              req_in1;
    logic [NUM_REQ-1:0][31:0]              req_in2;
    logic [NUM_REQ-1:0]                    req_lui;
    logic [NUM_REQ-1:0]                    req_aui;
    logic [NUM_REQ-1:0][ADDR_W-1:0]        req_pc;
    logic [NUM_REQ-1:0][PHYS_REG_BITS-1:0] req_tag;
    logic [NUM_REQ-1:0]                    req_grant;
    logic                                  flush;
    logic                                  cdb_valid;
    logic                                  cdb_ready;
    logic [31:0]                           cdb_value;
    logic [PHYS_REG_BITS-1:0]              cdb_tag;
    logic [31:0]                           issued_count;

    modport slave (
        input  req_valid, req_func, req_in1, req_in2, req_lui, req_aui,
        input  req_pc, req_tag, flush, cdb_ready,
        output req_grant, cdb_valid, cdb_value, cdb_tag, issued_count
    );

    modport master (
        output req_valid, req_func, req_in1, req_in2, req_lui, req_aui,
        output req_pc, req_tag, flush, cdb_ready,
        input  req_grant, cdb_valid, cdb_value, cdb_tag, issued_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: round-robin arbitration of NUM_REQ requesters onto one
// ALU, followed by an EX -> WB pipeline that broadcasts results on the CDB.
module alu_issue_ctrl #(
    parameter int NUM_REQ       = 4,
    parameter int ALU_FUNC_W    = 4,
    parameter int ADDR_W        = 32,
    parameter int PHYS_REG_BITS = 6
) (
    input  logic            clock,
    input  logic            reset,
    alu_issue_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [ALU_FUNC_W-1:0] ALU_ADD  = ALU_FUNC_W'(0);
    localparam logic [ALU_FUNC_W-1:0] ALU_SUB  = ALU_FUNC_W'(1);
    localparam logic [ALU_FUNC_W-1:0] ALU_AND  = ALU_FUNC_W'(2);
    localparam logic [ALU_FUNC_W-1:0] ALU_OR   = ALU_FUNC_W'(3);
    localparam logic [ALU_FUNC_W-1:0] ALU_XOR  = ALU_FUNC_W'(4);
    localparam logic [ALU_FUNC_W-1:0] ALU_SLL  = ALU_FUNC_W'(5);
    localparam logic [ALU_FUNC_W-1:0] ALU_SRL  = ALU_FUNC_W'(6);
    localparam logic [ALU_FUNC_W-1:0] ALU_SRA  = ALU_FUNC_W'(7);
    localparam logic [ALU_FUNC_W-1:0] ALU_SLT  = ALU_FUNC_W'(8);
    localparam logic [ALU_FUNC_W-1:0] ALU_SLTU = ALU_FUNC_W'(9);

    // Team ALU: LUI/AUIPC override the function code; unknown codes give 0.
    function automatic logic [31:0] alu_exec(
        input logic [ALU_FUNC_W-1:0] func,
        input logic [31:0]           in1,
        input logic [31:0]           in2,
        input logic                  lui,
        input logic                  aui,
        input logic [ADDR_W-1:0]     pc
    );
        logic signed [31:0] s1;
        logic signed [31:0] s2;
        logic        [31:0] res;
        s1 = $signed(in1);
        s2 = $signed(in2);
        if (lui) begin
            res = in2;
        end else if (aui) begin
            res = 32'(pc) + in2;
        end else begin
            case (func)
                ALU_ADD:  res = in1 + in2;
                ALU_SUB:  res = in1 - in2;
                ALU_AND:  res = in1 & in2;
                ALU_OR:   res = in1 | in2;
                ALU_XOR:  res = in1 ^ in2;
                ALU_SLL:  res = in1 << in2[4:0];
                ALU_SRL:  res = in1 >> in2[4:0];
                ALU_SRA:  res = s1 >>> in2[4:0];
                ALU_SLT:  res = (s1 < s2) ? 32'd1 : 32'd0;
                ALU_SLTU: res = (in1 < in2) ? 32'd1 : 32'd0;
                default:  res = 32'd0;
            endcase
        end
        return res;
    endfunction

    logic [PTR_W-1:0]         r_rr_ptr;
    logic [31:0]              r_issued_cnt;

    logic                     r_vld_p1;
    logic [ALU_FUNC_W-1:0]    r_func_p1;
    logic [31:0]              r_in1_p1;
    logic [31:0]              r_in2_p1;
    logic                     r_lui_p1;
    logic                     r_aui_p1;
    logic [ADDR_W-1:0]        r_pc_p1;
    logic [PHYS_REG_BITS-1:0] r_tag_p1;

    logic                     r_vld_p2;
    logic [31:0]              r_val_p2;
    logic [PHYS_REG_BITS-1:0] r_tag_p2;

    logic                     w_wb_free;
    logic                     w_ex_free;
    logic                     w_adv;
    logic [NUM_REQ-1:0]       w_grant;
    logic                     w_any;
    logic [PTR_W-1:0]         w_gidx;
    logic [PTR_W-1:0]         w_scan;
    int                       w_sum;
    logic [31:0]              w_alu_p1;

    assign w_wb_free = !r_vld_p2 || bus.cdb_ready;
    assign w_ex_free = !r_vld_p1 || w_wb_free;
    assign w_adv     = r_vld_p1 && w_wb_free;

    // Round-robin pick: scan upward from r_rr_ptr with wrap; first valid wins.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        w_sum   = 0;
        w_scan  = '0;
        if (w_ex_free && !bus.flush && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_sum = int'(r_rr_ptr) + k;
                if (w_sum >= NUM_REQ) begin
                    w_sum = w_sum - NUM_REQ;
                end
                w_scan = PTR_W'(w_sum);
                if (!w_any && bus.req_valid[w_scan]) begin
                    w_any  = 1'b1;
                    w_gidx = w_scan;
                end
            end
            if (w_any) begin
                w_grant[w_gidx] = 1'b1;
            end
        end
    end

    // Pointer moves past the winner; issue counter counts every grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_issued_cnt <= '0;
        end else if (w_any) begin
            r_rr_ptr     <= (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);
            r_issued_cnt <= r_issued_cnt + 32'd1;
        end
    end

    // ---- issue -> EX (p1) ----
    // EX occupancy: flush squashes, a grant refills, an advance empties.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else if (bus.flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_any) begin
            r_vld_p1 <= 1'b1;
        end else if (w_adv) begin
            r_vld_p1 <= 1'b0;
        end
    end

    // EX operand fields latch the granted requester; meaningless while invalid.
    always_ff @(posedge clock) begin
        if (w_any) begin
            r_func_p1 <= bus.req_func[w_gidx];
            r_in1_p1  <= bus.req_in1[w_gidx];
            r_in2_p1  <= bus.req_in2[w_gidx];
            r_lui_p1  <= bus.req_lui[w_gidx];
            r_aui_p1  <= bus.req_aui[w_gidx];
            r_pc_p1   <= bus.req_pc[w_gidx];
            r_tag_p1  <= bus.req_tag[w_gidx];
        end
    end

    // ---- EX (p1) -> WB (p2) ----
    assign w_alu_p1 = alu_exec(r_func_p1, r_in1_p1, r_in2_p1, r_lui_p1, r_aui_p1, r_pc_p1);

    // WB captures on advance, holds under backpressure, drains when consumed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p2 <= 1'b0;
            r_val_p2 <= '0;
            r_tag_p2 <= '0;
        end else if (bus.flush) begin
            r_vld_p2 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p2 <= 1'b1;
            r_val_p2 <= w_alu_p1;
            r_tag_p2 <= r_tag_p1;
        end else if (w_wb_free) begin
            r_vld_p2 <= 1'b0;
        end
    end

    // ---- WB (p2) -> CDB ----
    assign bus.req_grant    = w_grant;
    assign bus.cdb_valid    = r_vld_p2;
    assign bus.cdb_value    = r_val_p2;
    assign bus.cdb_tag      = r_tag_p2;
    assign bus.issued_count = r_issued_cnt;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed scenarios plus a randomized run
// checked against a queue-based model of in-flight ops.
module tb_alu_issue_ctrl;
    localparam int N  = 4;
    localparam int PW = 2;
    localparam int FW = 4;
    localparam int AW = 32;
    localparam int TW = 6;

    localparam logic [FW-1:0] F_ADD = 4'd0;
    localparam logic [FW-1:0] F_SUB = 4'd1;
    localparam logic [FW-1:0] F_AND = 4'd2;
    localparam logic [FW-1:0] F_OR  = 4'd3;
    localparam logic [FW-1:0] F_XOR = 4'd4;

    typedef struct {
        logic [31:0]   val;
        logic [TW-1:0] tag;
        bit            in_wb;
    } op_t;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_issue_ctrl_if #(.NUM_REQ(N), .ALU_FUNC_W(FW), .ADDR_W(AW), .PHYS_REG_BITS(TW)) bus ();

    alu_issue_ctrl #(.NUM_REQ(N), .ALU_FUNC_W(FW), .ADDR_W(AW), .PHYS_REG_BITS(TW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_alu(input logic [FW-1:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic lui,
                                            input logic aui, input logic [31:0] pc);
        if (lui) return b;
        if (aui) return pc + b;
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return $unsigned($signed(a) >>> b[4:0]);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_inputs;
        bus.req_valid = '0;
        bus.req_func  = '0;
        bus.req_in1   = '0;
        bus.req_in2   = '0;
        bus.req_lui   = '0;
        bus.req_aui   = '0;
        bus.req_pc    = '0;
        bus.req_tag   = '0;
        bus.flush     = 1'b0;
        bus.cdb_ready = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [FW-1:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic lui, input logic aui,
                           input logic [31:0] pc, input logic [TW-1:0] tag);
        bus.req_func[PW'(i)] = f;
        bus.req_in1[PW'(i)]  = a;
        bus.req_in2[PW'(i)]  = b;
        bus.req_lui[PW'(i)]  = lui;
        bus.req_aui[PW'(i)]  = aui;
        bus.req_pc[PW'(i)]   = pc;
        bus.req_tag[PW'(i)]  = tag;
    endtask

    task automatic next_cyc;
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear_inputs();
        next_cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_inputs();
        bus.req_valid = 4'b1111;
        next_cyc();
        next_cyc();
        n_cmp++; if (bus.req_grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b expected 0000", bus.req_grant); end
        n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cdb_valid: got %b expected 0", bus.cdb_valid); end
        n_cmp++; if (bus.cdb_value !== 32'd0) begin n_bad++; $display("FAIL reset_cdb_value: got %h expected 0", bus.cdb_value); end
        n_cmp++; if (bus.cdb_tag !== 6'd0) begin n_bad++; $display("FAIL reset_cdb_tag: got %h expected 0", bus.cdb_tag); end
        n_cmp++; if (bus.issued_count !== 32'd0) begin n_bad++; $display("FAIL reset_issued: got %0d expected 0", bus.issued_count); end
    endtask

    task automatic test_single_op;
        do_reset();
        set_req(0, F_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 6'd3);
        bus.req_valid = 4'b0001;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b expected 0001", bus.req_grant); end
        next_cyc();
        bus.req_valid = 4'b0000;
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL single_c1_valid: got %b expected 0", bus.cdb_valid); end
        next_cyc();
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b1) begin n_bad++; $display("FAIL single_c2_valid: got %b expected 1", bus.cdb_valid); end
        n_cmp++; if (bus.cdb_value !== 32'd12) begin n_bad++; $display("FAIL single_value: got %0d expected 12", bus.cdb_value); end
        n_cmp++; if (bus.cdb_tag !== 6'd3) begin n_bad++; $display("FAIL single_tag: got %0d expected 3", bus.cdb_tag); end
        next_cyc();
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL single_c3_valid: got %b expected 0", bus.cdb_valid); end
        n_cmp++; if (bus.issued_count !== 32'd1) begin n_bad++; $display("FAIL single_issued: got %0d expected 1", bus.issued_count); end
    endtask

    task automatic test_fairness;
        logic [N-1:0] exp_g;
        int           et;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, F_ADD, 32'(i), 32'd100, 1'b0, 1'b0, 32'd0, TW'(i));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) bus.req_valid = 4'b0000;
            #1;
            exp_g = (k < 5) ? (N'(1) << (k % N)) : '0;
            n_cmp++; if (bus.req_grant !== exp_g) begin n_bad++; $display("FAIL fair_grant c%0d: got %b expected %b", k, bus.req_grant, exp_g); end
            n_cmp++; if (bus.cdb_valid !== (k >= 2 && k <= 6)) begin n_bad++; $display("FAIL fair_valid c%0d: got %b expected %b", k, bus.cdb_valid, (k >= 2 && k <= 6)); end
            if (k >= 2 && k <= 6) begin
                et = (k - 2) % N;
                n_cmp++; if (bus.cdb_tag !== TW'(et)) begin n_bad++; $display("FAIL fair_tag c%0d: got %0d expected %0d", k, bus.cdb_tag, et); end
                n_cmp++; if (bus.cdb_value !== 32'(100 + et)) begin n_bad++; $display("FAIL fair_value c%0d: got %0d expected %0d", k, bus.cdb_value, 100 + et); end
            end
            n_cmp++; if (bus.issued_count !== 32'((k < 5) ? k : 5)) begin n_bad++; $display("FAIL fair_issued c%0d: got %0d expected %0d", k, bus.issued_count, (k < 5) ? k : 5); end
            next_cyc();
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        bus.cdb_ready = 1'b0;
        set_req(0, F_ADD, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0, 6'd1);
        bus.req_valid = 4'b0001;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0001) begin n_bad++; $display("FAIL bp_grant0: got %b expected 0001", bus.req_grant); end
        next_cyc();
        set_req(1, F_SUB, 32'd10, 32'd3, 1'b0, 1'b0, 32'd0, 6'd2);
        bus.req_valid = 4'b0010;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0010) begin n_bad++; $display("FAIL bp_grant1: got %b expected 0010", bus.req_grant); end
        next_cyc();
        set_req(2, F_XOR, 32'hF0, 32'hFF, 1'b0, 1'b0, 32'd0, 6'd5);
        bus.req_valid = 4'b0100;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_cmp++; if (bus.req_grant !== 4'b0000) begin n_bad++; $display("FAIL bp_stall_grant s%0d: got %b expected 0000", s, bus.req_grant); end
            n_cmp++; if (bus.cdb_valid !== 1'b1 || bus.cdb_value !== 32'd3 || bus.cdb_tag !== 6'd1) begin
                n_bad++; $display("FAIL bp_stall_hold s%0d: got v=%b val=%0d tag=%0d expected v=1 val=3 tag=1", s, bus.cdb_valid, bus.cdb_value, bus.cdb_tag);
            end
            next_cyc();
        end
        bus.cdb_ready = 1'b1;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0100) begin n_bad++; $display("FAIL bp_release_grant: got %b expected 0100", bus.req_grant); end
        n_cmp++; if (bus.cdb_value !== 32'd3 || bus.cdb_tag !== 6'd1) begin n_bad++; $display("FAIL bp_first: got val=%0d tag=%0d expected val=3 tag=1", bus.cdb_value, bus.cdb_tag); end
        next_cyc();
        bus.req_valid = 4'b0000;
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b1 || bus.cdb_value !== 32'd7 || bus.cdb_tag !== 6'd2) begin
            n_bad++; $display("FAIL bp_second: got v=%b val=%0d tag=%0d expected v=1 val=7 tag=2", bus.cdb_valid, bus.cdb_value, bus.cdb_tag);
        end
        next_cyc();
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b1 || bus.cdb_value !== 32'h0F || bus.cdb_tag !== 6'd5) begin
            n_bad++; $display("FAIL bp_third: got v=%b val=%h tag=%0d expected v=1 val=0f tag=5", bus.cdb_valid, bus.cdb_value, bus.cdb_tag);
        end
        next_cyc();
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b expected 0", bus.cdb_valid); end
        n_cmp++; if (bus.issued_count !== 32'd3) begin n_bad++; $display("FAIL bp_issued: got %0d expected 3", bus.issued_count); end
    endtask

    task automatic test_lui_aui;
        do_reset();
        set_req(0, F_SUB, 32'hDEADBEEF, 32'h12345000, 1'b1, 1'b0, 32'h40, 6'd7);
        bus.req_valid = 4'b0001;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0001) begin n_bad++; $display("FAIL lui_grant: got %b expected 0001", bus.req_grant); end
        next_cyc();
        set_req(1, F_AND, 32'hFFFFFFFF, 32'h2000, 1'b0, 1'b1, 32'h100, 6'd8);
        bus.req_valid = 4'b0010;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0010) begin n_bad++; $display("FAIL aui_grant: got %b expected 0010", bus.req_grant); end
        next_cyc();
        bus.req_valid = 4'b0000;
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b1 || bus.cdb_value !== 32'h12345000 || bus.cdb_tag !== 6'd7) begin
            n_bad++; $display("FAIL lui_result: got v=%b val=%h tag=%0d expected v=1 val=12345000 tag=7", bus.cdb_valid, bus.cdb_value, bus.cdb_tag);
        end
        next_cyc();
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b1 || bus.cdb_value !== 32'h2100 || bus.cdb_tag !== 6'd8) begin
            n_bad++; $display("FAIL aui_result: got v=%b val=%h tag=%0d expected v=1 val=2100 tag=8", bus.cdb_valid, bus.cdb_value, bus.cdb_tag);
        end
    endtask

    task automatic test_flush;
        do_reset();
        bus.cdb_ready = 1'b0;
        set_req(0, F_ADD, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 6'd1);
        bus.req_valid = 4'b0001;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0001) begin n_bad++; $display("FAIL flush_pre_grant0: got %b expected 0001", bus.req_grant); end
        next_cyc();
        set_req(1, F_ADD, 32'd5, 32'd6, 1'b0, 1'b0, 32'd0, 6'd2);
        bus.req_valid = 4'b0010;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0010) begin n_bad++; $display("FAIL flush_pre_grant1: got %b expected 0010", bus.req_grant); end
        next_cyc();
        bus.req_valid = 4'b0100;
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0000) begin n_bad++; $display("FAIL flush_grant: got %b expected 0000", bus.req_grant); end
        n_cmp++; if (bus.cdb_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre_valid: got %b expected 1", bus.cdb_valid); end
        next_cyc();
        bus.flush = 1'b0;
        bus.req_valid = 4'b1111;
        bus.cdb_ready = 1'b1;
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_post_valid: got %b expected 0", bus.cdb_valid); end
        n_cmp++; if (bus.issued_count !== 32'd2) begin n_bad++; $display("FAIL flush_issued: got %0d expected 2", bus.issued_count); end
        n_cmp++; if (bus.req_grant !== 4'b0100) begin n_bad++; $display("FAIL flush_rr_hold: got %b expected 0100", bus.req_grant); end
        next_cyc();
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.cdb_ready = 1'b0;
        set_req(0, F_OR, 32'hA0, 32'h0B, 1'b0, 1'b0, 32'd0, 6'd9);
        bus.req_valid = 4'b0001;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0001) begin n_bad++; $display("FAIL areset_grant: got %b expected 0001", bus.req_grant); end
        next_cyc();
        bus.req_valid = 4'b0000;
        next_cyc();
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b1 || bus.cdb_value !== 32'hAB) begin
            n_bad++; $display("FAIL areset_pre: got v=%b val=%h expected v=1 val=ab", bus.cdb_valid, bus.cdb_value);
        end
        reset = 1'b1;
        bus.req_valid = 4'b1010;
        #1;
        n_cmp++; if (bus.cdb_valid !== 1'b0 || bus.cdb_value !== 32'd0 || bus.cdb_tag !== 6'd0) begin
            n_bad++; $display("FAIL areset_immediate: got v=%b val=%h tag=%0d expected v=0 val=0 tag=0", bus.cdb_valid, bus.cdb_value, bus.cdb_tag);
        end
        n_cmp++; if (bus.req_grant !== 4'b0000) begin n_bad++; $display("FAIL areset_grant_in_reset: got %b expected 0000", bus.req_grant); end
        next_cyc();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.req_grant !== 4'b0010) begin n_bad++; $display("FAIL areset_first_grant: got %b expected 0010", bus.req_grant); end
        bus.req_valid = 4'b0000;
        next_cyc();
    endtask

    task automatic test_random;
        op_t          q[$];
        op_t          t;
        int           rr;
        int           g;
        int           idx;
        logic [31:0]  cnt;
        logic [N-1:0] eg;
        bit           ev;
        rr  = 0;
        cnt = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.req_func[PW'(i)] = FW'($urandom_range(0, 9));
                bus.req_in1[PW'(i)]  = $urandom;
                bus.req_in2[PW'(i)]  = $urandom;
                bus.req_lui[PW'(i)]  = ($urandom_range(0, 7) == 0);
                bus.req_aui[PW'(i)]  = !bus.req_lui[PW'(i)] && ($urandom_range(0, 7) == 0);
                bus.req_pc[PW'(i)]   = $urandom;
                bus.req_tag[PW'(i)]  = TW'($urandom);
            end
            bus.req_valid = N'($urandom);
            bus.cdb_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            #1;
            // At most two ops are ever in flight; a third fits only if one leaves.
            g = -1;
            if (!bus.flush && (q.size() < 2 || bus.cdb_ready)) begin
                for (int k = 0; k < N; k++) begin
                    idx = (rr + k) % N;
                    if (g < 0 && ((bus.req_valid >> idx) & N'(1)) != '0) g = idx;
                end
            end
            eg = (g >= 0) ? (N'(1) << g) : '0;
            ev = (q.size() > 0) && q[0].in_wb;
            n_cmp++; if (bus.req_grant !== eg) begin n_bad++; $display("FAIL rand_grant c%0d: got %b expected %b", c, bus.req_grant, eg); end
            n_cmp++; if (bus.cdb_valid !== ev) begin n_bad++; $display("FAIL rand_valid c%0d: got %b expected %b", c, bus.cdb_valid, ev); end
            if (ev) begin
                n_cmp++; if (bus.cdb_value !== q[0].val || bus.cdb_tag !== q[0].tag) begin
                    n_bad++; $display("FAIL rand_result c%0d: got val=%h tag=%0d expected val=%h tag=%0d", c, bus.cdb_value, bus.cdb_tag, q[0].val, q[0].tag);
                end
            end
            n_cmp++; if (bus.issued_count !== cnt) begin n_bad++; $display("FAIL rand_issued c%0d: got %0d expected %0d", c, bus.issued_count, cnt); end
            @(posedge clock);
            if (bus.flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && q[0].in_wb && bus.cdb_ready) void'(q.pop_front());
                if (q.size() > 0 && !q[0].in_wb) begin
                    t = q[0];
                    t.in_wb = 1'b1;
                    q[0] = t;
                end
                if (g >= 0) begin
                    t.val = ref_alu(bus.req_func[PW'(g)], bus.req_in1[PW'(g)], bus.req_in2[PW'(g)],
                                    bus.req_lui[PW'(g)], bus.req_aui[PW'(g)], bus.req_pc[PW'(g)]);
                    t.tag = bus.req_tag[PW'(g)];
                    t.in_wb = 1'b0;
                    q.push_back(t);
                end
            end
            if (g >= 0) begin
                rr  = (g + 1) % N;
                cnt = cnt + 32'd1;
            end
            #2;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_lui_aui();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one ALU, minimum 2.
REQ-002 SHALL have port clock  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  NUM_REQ: requester i holds a ready-to-execute op.
REQ-005 SHALL have port req_func  input  NUM_REQ x ALU_FUNC: operation per requester.
REQ-006 SHALL have ports req_in1, req_in2  input  NUM_REQ x 32: operands per requester.
REQ-007 SHALL have ports req_lui, req_aui  input  NUM_REQ x 1: LUI / AUIPC select per requester.
REQ-008 SHALL have port req_pc  input  NUM_REQ x ADDR: instruction PC per requester.
REQ-009 SHALL have port req_tag  input  NUM_REQ x PHYS_REG_BITS: destination physical tag per requester.
REQ-010 SHALL have port req_grant  output  NUM_REQ: one-hot-or-zero combinational grant; requester drops its entry on the same edge.
REQ-011 SHALL have port flush  input  1: synchronous squash of all in-flight ops (mispredict recovery).
REQ-012 SHALL have port cdb_valid  output  1: result present for broadcast.
REQ-013 SHALL have port cdb_ready  input  1: broadcast bus accepts result this cycle.
REQ-014 SHALL have ports cdb_value  output  32 and cdb_tag  output  PHYS_REG_BITS: result and destination tag.
REQ-015 SHALL have port issued_count  output  32: number of ops granted since reset.

Function
REQ-016 SHALL contain two pipeline registers: EX (op fields + ex_valid) and WB (value, tag, wb_valid).
REQ-017 SHALL instantiate the team ALU combinationally between EX and WB, driven by EX fields; lui result = in2, aui result = pc + in2, else per func.
REQ-018 SHALL compute wb_free = !wb_valid || cdb_ready; ex_free = !ex_valid || wb_free.
REQ-019 SHALL assert at most one req_grant bit, only when ex_free && !flush && reset low, chosen among req_valid bits by round-robin.
REQ-020 Round-robin SHALL search from index rr_ptr upward with wrap-around from NUM_REQ-1 to 0; first valid index wins.
REQ-021 On a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ at the next edge; with no grant rr_ptr SHALL hold.
REQ-022 On a grant, EX SHALL capture the granted requester's fields and set ex_valid at the next edge.
REQ-023 If ex_valid && wb_free, WB SHALL capture ALU output and EX tag and set wb_valid; EX SHALL clear unless refilled by a simultaneous grant.
REQ-024 If wb_valid && !cdb_ready, WB and EX SHALL hold unchanged (backpressure), and no grant SHALL issue while EX is full.
REQ-025 If wb_valid && cdb_ready and EX empty, wb_valid SHALL clear at the next edge.
REQ-026 cdb_valid SHALL equal wb_valid; cdb_value/cdb_tag SHALL be WB registers, stable while cdb_valid && !cdb_ready.
REQ-027 Latency: grant in cycle N -> cdb_valid in cycle N+2 when unstalled; throughput one result per cycle with cdb_ready held high.
REQ-028 flush SHALL clear ex_valid and wb_valid at the next edge, regardless of cdb_ready; rr_ptr and issued_count SHALL hold.
REQ-029 issued_count SHALL increment by 1 on each edge where any req_grant bit is high; wraps modulo 2^32.
REQ-030 req_grant SHALL depend only on req_valid, rr_ptr, ex/wb state, cdb_ready and flush; no combinational path from operand inputs.

Reset
REQ-031 While reset is high: ex_valid=0, wb_valid=0, rr_ptr=0, issued_count=0, cdb_value=0, cdb_tag=0, req_grant=0.
REQ-032 Reset asserted mid-operation SHALL discard EX and WB contents immediately, without waiting for a clock edge.
REQ-033 First grant after reset deassertion SHALL go to the lowest-index valid requester.

Verification
REQ-034 Single op: req_valid=0001, func ALU_ADD, in1=5, in2=7, tag=3 -> grant=0001 cycle 0; cdb_valid, value=12, tag=3 in cycle 2.
REQ-035 Fairness: req_valid=1111 held, cdb_ready=1 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; issued_count=5.
REQ-036 Backpressure: two ops issued, cdb_ready=0 for 3 cycles -> cdb_value held, no grant while EX full; both results appear in order once cdb_ready=1.
REQ-037 LUI/AUI: req_lui with in2=0x12345000 -> 0x12345000; req_aui with pc=0x100, in2=0x2000 -> 0x2100; in1 ignored in both.
REQ-038 Flush: flush pulsed with EX and WB full and cdb_ready=0 -> cdb_valid=0 next cycle, req_grant=0 during flush cycle, issued_count unchanged.
REQ-039 Async reset: reset raised between edges with wb_valid=1 -> cdb_valid=0 immediately; after release, req_valid=1010 -> grant=0010.
